// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low seven-segment bus and rebuilds the hex nibble on each digit.
// Each stable, one-hot-anode dwell commits exactly once into the per-digit value/valid/err bank.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    upd,
    output logic [2:0]              upd_idx
);

    localparam int unsigned SW = NUM_DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CntMax  = '1;

    typedef enum logic [0:0] {StSeek, StHold} state_e;

    logic [SW-1:0]           sync1_q, sync2_q, prev_q;
    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    upd_q;
    logic [2:0]              upd_idx_q, idx;

    logic [NUM_DIGITS-1:0] sample_an;
    logic [6:0]            sample_seg;
    logic                  same, one_hot, commit;
    logic [3:0]            low_cnt;
    logic                  dec_hit, dec_blank;
    logic [3:0]            dec_nib;

    assign sample_an  = sync2_q[SW-1:7];
    assign sample_seg = sync2_q[6:0];
    assign same       = (sync2_q == prev_q);

    always_comb begin
        low_cnt = '0;
        idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sample_an[i]) begin
                low_cnt = low_cnt + 4'd1;
                idx     = 3'(i);
            end
        end
        one_hot = (low_cnt == 4'd1);
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_nib = 4'h0;
        case (sample_seg)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: dec_hit = 1'b0;
        endcase
        dec_blank = (sample_seg == 7'h7F);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = same ? ((cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1) : '0;
        commit  = 1'b0;
        case (state_q)
            StSeek: begin
                if (!one_hot) begin
                    cnt_d = '0;
                end else if (same && cnt_q == CntLast) begin
                    commit  = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!same) state_d = StSeek;
            end
            default: state_d = StSeek;
        endcase
    end

    // Selected digit is the single low anode; commit already implies one-hot.
    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        err_d   = err_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (commit && !sample_an[d]) begin
                if (dec_hit) begin
                    value_d[4*d +: 4] = dec_nib;
                    valid_d[d]        = 1'b1;
                    err_d[d]          = 1'b0;
                end else if (dec_blank) begin
                    valid_d[d] = 1'b0;
                    err_d[d]   = 1'b0;
                end else begin
                    err_d[d] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            prev_q    <= '1;
            state_q   <= StSeek;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            sync1_q   <= {an, seg};
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            upd_q     <= commit;
            if (commit) upd_idx_q <= idx;
        end
    end

    assign value   = value_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;

endmodule
